// File: rtl/wait_event_engine.sv
// wait_event_engine: N-channel wait engine that reports done, timeout or error for one sequencer command.
// Optional build macro WAIT_EVENT_MASK_EN adds i_mask for bit-masked EQ/NEQ compares.
module wait_event_engine #(
  parameter int WAIT_SIZE     = 5,
  parameter int WAIT_WIDTH    = 32,
  parameter int TIMEOUT_WIDTH = 32,
  parameter int SEL_WIDTH     = ($clog2(WAIT_SIZE) > 0) ? $clog2(WAIT_SIZE) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [WAIT_SIZE*WAIT_WIDTH-1:0] wait_signals,
  input  logic                            i_start,
  input  logic [SEL_WIDTH-1:0]            i_sel,
  input  logic [2:0]                      i_mode,
  input  logic [WAIT_WIDTH-1:0]           i_value,
  input  logic [TIMEOUT_WIDTH-1:0]        i_timeout,
  input  logic                            i_abort,
`ifdef WAIT_EVENT_MASK_EN
  input  logic [WAIT_WIDTH-1:0]           i_mask,
`endif
  output logic                            o_busy,
  output logic                            o_done,
  output logic                            o_timeout,
  output logic                            o_err,
  output logic [TIMEOUT_WIDTH-1:0]        o_elapsed
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] MODE_HIGH = 3'd0;
  localparam logic [2:0] MODE_LOW  = 3'd1;
  localparam logic [2:0] MODE_RISE = 3'd2;
  localparam logic [2:0] MODE_FALL = 3'd3;
  localparam logic [2:0] MODE_EQ   = 3'd4;
  localparam logic [2:0] MODE_NEQ  = 3'd5;

  localparam logic [SEL_WIDTH:0] SEL_LIMIT = (SEL_WIDTH+1)'(WAIT_SIZE);

  logic [1:0]               state_r;
  logic [SEL_WIDTH-1:0]     sel_r;
  logic [2:0]               mode_r;
  logic [WAIT_WIDTH-1:0]    value_r;
  logic [TIMEOUT_WIDTH-1:0] timeout_r;
  logic                     prev_r;
  logic [WAIT_WIDTH-1:0]    mask_s;

`ifdef WAIT_EVENT_MASK_EN
  logic [WAIT_WIDTH-1:0]    mask_r;
  assign mask_s = mask_r;
`else
  assign mask_s = '1;
`endif

  function automatic logic [WAIT_WIDTH-1:0] pick_channel(
    input logic [WAIT_SIZE*WAIT_WIDTH-1:0] vec,
    input logic [SEL_WIDTH-1:0]            idx
  );
    logic [WAIT_WIDTH-1:0] res;
    res = '0;
    for (int k = 0; k < WAIT_SIZE; k++) begin
      res = (idx == SEL_WIDTH'(k)) ? vec[k*WAIT_WIDTH +: WAIT_WIDTH] : res;
    end
    return res;
  endfunction

  function automatic logic pick_lsb(
    input logic [WAIT_SIZE*WAIT_WIDTH-1:0] vec,
    input logic [SEL_WIDTH-1:0]            idx
  );
    logic res;
    res = 1'b0;
    for (int k = 0; k < WAIT_SIZE; k++) begin
      res = (idx == SEL_WIDTH'(k)) ? vec[k*WAIT_WIDTH] : res;
    end
    return res;
  endfunction

  function automatic logic eval_match(
    input logic [2:0]            mode,
    input logic [WAIT_WIDTH-1:0] s,
    input logic                  prev,
    input logic [WAIT_WIDTH-1:0] value,
    input logic [WAIT_WIDTH-1:0] mask
  );
    logic res;
    case (mode)
      MODE_HIGH: res = s[0];
      MODE_LOW:  res = ~s[0];
      MODE_RISE: res = s[0] & ~prev;
      MODE_FALL: res = ~s[0] & prev;
      MODE_EQ:   res = ((s & mask) == (value & mask));
      MODE_NEQ:  res = ((s & mask) != (value & mask));
      default:   res = 1'b0;
    endcase
    return res;
  endfunction

  logic                     start_bit_s;
  logic [WAIT_WIDTH-1:0]    wait_chan_s;
  logic                     cmd_bad_s;
  logic                     match_s;
  logic                     expire_s;
  logic [TIMEOUT_WIDTH:0]   elapsed_inc_s;
  logic [TIMEOUT_WIDTH-1:0] elapsed_next_s;

  // Channel selection, match evaluation and the saturating elapsed counter.
  always_comb begin
    start_bit_s    = pick_lsb(wait_signals, i_sel);
    wait_chan_s    = pick_channel(wait_signals, sel_r);
    cmd_bad_s      = ({1'b0, i_sel} >= SEL_LIMIT) || (i_mode > MODE_NEQ);
    match_s        = eval_match(mode_r, wait_chan_s, prev_r, value_r, mask_s);
    elapsed_inc_s  = {1'b0, o_elapsed} + {{TIMEOUT_WIDTH{1'b0}}, 1'b1};
    elapsed_next_s = (&o_elapsed) ? o_elapsed : elapsed_inc_s[TIMEOUT_WIDTH-1:0];
    // compared at full width so a saturated counter can never alias a timeout
    expire_s       = (timeout_r != '0) && (elapsed_inc_s == {1'b0, timeout_r});
  end

  // Command FSM with registered status outputs; DONE accepts a new start like IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      sel_r     <= '0;
      mode_r    <= 3'd0;
      value_r   <= '0;
      timeout_r <= '0;
      prev_r    <= 1'b0;
`ifdef WAIT_EVENT_MASK_EN
      mask_r    <= '0;
`endif
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_timeout <= 1'b0;
      o_err     <= 1'b0;
      o_elapsed <= '0;
    end else begin
      o_done    <= 1'b0;
      o_timeout <= 1'b0;
      o_err     <= 1'b0;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            sel_r     <= i_sel;
            mode_r    <= i_mode;
            value_r   <= i_value;
            timeout_r <= i_timeout;
`ifdef WAIT_EVENT_MASK_EN
            mask_r    <= i_mask;
`endif
            prev_r    <= start_bit_s;
            o_elapsed <= '0;
            if (cmd_bad_s) begin
              state_r <= ST_DONE;
              o_busy  <= 1'b0;
              o_done  <= 1'b1;
              o_err   <= 1'b1;
            end else begin
              state_r <= ST_WAIT;
              o_busy  <= 1'b1;
            end
          end else begin
            state_r <= ST_IDLE;
            o_busy  <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (i_abort) begin
            state_r <= ST_IDLE;
            o_busy  <= 1'b0;
          end else begin
            o_elapsed <= elapsed_next_s;
            prev_r    <= wait_chan_s[0];
            if (match_s) begin
              state_r <= ST_DONE;
              o_busy  <= 1'b0;
              o_done  <= 1'b1;
            end else if (expire_s) begin
              state_r   <= ST_DONE;
              o_busy    <= 1'b0;
              o_done    <= 1'b1;
              o_timeout <= 1'b1;
            end else begin
              state_r <= ST_WAIT;
              o_busy  <= 1'b1;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
          o_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wait_event_engine.sv
// tb_wait_event_engine: randomized scoreboard bench for wait_event_engine with a cycle-level reference model.
// Builds with or without WAIT_EVENT_MASK_EN.
`timescale 1ns/1ps
module tb_wait_event_engine;

  localparam int WS  = 5;
  localparam int WW  = 32;
  localparam int TW  = 32;
  localparam int SW  = 3;
  localparam int LEN = 30;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [WS*WW-1:0] wait_signals;
  logic           i_start;
  logic [SW-1:0]  i_sel;
  logic [2:0]     i_mode;
  logic [WW-1:0]  i_value;
  logic [TW-1:0]  i_timeout;
  logic           i_abort;
`ifdef WAIT_EVENT_MASK_EN
  logic [WW-1:0]  i_mask;
`endif
  logic           o_busy, o_done, o_timeout, o_err;
  logic [TW-1:0]  o_elapsed;

  wait_event_engine #(.WAIT_SIZE(WS), .WAIT_WIDTH(WW), .TIMEOUT_WIDTH(TW)) dut (
    .clk(clk), .rst_n(rst_n), .wait_signals(wait_signals),
    .i_start(i_start), .i_sel(i_sel), .i_mode(i_mode), .i_value(i_value),
    .i_timeout(i_timeout), .i_abort(i_abort),
`ifdef WAIT_EVENT_MASK_EN
    .i_mask(i_mask),
`endif
    .o_busy(o_busy), .o_done(o_done), .o_timeout(o_timeout), .o_err(o_err),
    .o_elapsed(o_elapsed)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    bit            tmo;
    bit            err;
    logic [TW-1:0] elapsed;
  } exp_t;

  exp_t          exp_q[$];
  int            checks = 0;
  int            passes = 0;
  int            cyc = 0;
  logic [WW-1:0] traj [0:LEN];
  logic [WW-1:0] cur_mask = '1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expected completion.
  always @(negedge clk) begin
    exp_t e;
    if (o_done === 1'b1) begin
      check("done_pending", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("done_cycle",   64'(cyc),       64'(e.cyc));
        check("done_timeout", 64'(o_timeout), 64'(e.tmo));
        check("done_err",     64'(o_err),     64'(e.err));
        check("done_elapsed", 64'(o_elapsed), 64'(e.elapsed));
        check("busy_at_done", 64'(o_busy),    64'd0);
      end
    end else if (o_timeout === 1'b1 || o_err === 1'b1) begin
      check("stray_flag", 64'({o_timeout, o_err}), 64'd0);
    end
  end

  function automatic bit ref_match(input int mode, input logic [WW-1:0] s, input bit prev,
                                   input logic [WW-1:0] v, input logic [WW-1:0] m);
    case (mode)
      0: return s[0];
      1: return !s[0];
      2: return s[0] && !prev;
      3: return !s[0] && prev;
      4: return (s & m) == (v & m);
      5: return (s & m) != (v & m);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [WS*WW-1:0] compose(input int sel, input logic [WW-1:0] ch);
    logic [WS*WW-1:0] r;
    for (int j = 0; j < WS; j++) r[j*WW +: WW] = (j == sel) ? ch : WW'($urandom);
    return r;
  endfunction

  // Selected-channel trajectory: condition false before cycle d, true from d on.
  task automatic gen_traj(input int mode, input logic [WW-1:0] value, input int d);
    for (int k = 0; k <= LEN; k++) begin
      logic [WW-1:0] r;
      r = WW'($urandom);
      case (mode)
        0, 2: r[0] = (k >= d);
        1, 3: r[0] = (k < d);
        4: begin
          if (k >= d) r = value;
          else if (r == value) r = ~value;
          else r = r;
        end
        5: begin
          if (k < d) r = value;
          else if (r == value) r = ~value;
          else r = r;
        end
        default: r = r;
      endcase
      traj[k] = r;
    end
  endtask

  task automatic fill_traj(input logic [WW-1:0] v);
    for (int k = 0; k <= LEN; k++) traj[k] = v;
  endtask

  // Issues one command; the reference model predicts its outcome from traj before driving it.
  task automatic run_cmd(input int sel, input int mode, input logic [WW-1:0] value,
                         input logic [TW-1:0] tmo, input int abort_at, input bit abort_with_start);
    exp_t          e;
    bit            prev, finished, timed;
    int            stop, t0, abort_k;
    logic [WW-1:0] m;
`ifdef WAIT_EVENT_MASK_EN
    m = cur_mask;
    i_mask = cur_mask;
`else
    m = '1;
`endif
    i_start = 1'b1; i_sel = SW'(sel); i_mode = 3'(mode); i_value = value;
    i_timeout = tmo; i_abort = abort_with_start;
    wait_signals = compose(sel, traj[0]);
    t0 = cyc;
    if (sel >= WS || mode > 5) begin
      e.cyc = t0 + 1; e.tmo = 1'b0; e.err = 1'b1; e.elapsed = '0;
      exp_q.push_back(e);
      @(negedge clk);
      i_start = 1'b0; i_abort = 1'b0;
      check("err_busy", 64'(o_busy), 64'd0);
      return;
    end
    prev = traj[0][0]; finished = 1'b0; timed = 1'b0; stop = LEN;
    for (int k = 1; k <= LEN; k++) begin
      if (k == abort_at) begin stop = k; break; end
      if (ref_match(mode, traj[k], prev, value, m)) begin finished = 1'b1; stop = k; break; end
      if (tmo != '0 && k == int'(tmo)) begin finished = 1'b1; timed = 1'b1; stop = k; break; end
      prev = traj[k][0];
    end
    abort_k = finished ? 0 : stop;
    if (finished) begin
      e.cyc = t0 + 1 + stop; e.tmo = timed; e.err = 1'b0; e.elapsed = TW'(stop);
      exp_q.push_back(e);
    end
    for (int k = 1; k <= stop; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("busy_after_start", 64'(o_busy), 64'd1);
        check("elapsed_cleared", 64'(o_elapsed), 64'd0);
      end
      i_abort = (k == abort_k);
      // starts while busy must be ignored
      i_start = ($urandom_range(0, 3) == 0);
      i_sel = SW'($urandom_range(0, 7)); i_mode = 3'($urandom_range(0, 7));
      i_value = WW'($urandom); i_timeout = TW'($urandom_range(1, 3));
      wait_signals = compose(sel, traj[k]);
    end
    @(negedge clk);
    i_start = 1'b0; i_abort = 1'b0;
    if (!finished) begin
      check("busy_after_abort", 64'(o_busy), 64'd0);
      check("no_done_after_abort", 64'(o_done), 64'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish before 500000ns");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; i_start = 1'b0; i_sel = '0; i_mode = 3'd0; i_value = '0;
    i_timeout = '0; i_abort = 1'b0; wait_signals = '0;
`ifdef WAIT_EVENT_MASK_EN
    i_mask = '1;
`endif
    repeat (3) @(negedge clk);
    check("reset_busy",    64'(o_busy),    64'd0);
    check("reset_done",    64'(o_done),    64'd0);
    check("reset_timeout", 64'(o_timeout), 64'd0);
    check("reset_err",     64'(o_err),     64'd0);
    check("reset_elapsed", 64'(o_elapsed), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // RISE on ch0 ten cycles after start, no timeout
    gen_traj(2, '0, 10);
    run_cmd(0, 2, '0, '0, LEN + 1, 1'b0);
    // EQ on ch2 with the level already true
    fill_traj(32'h0000_0072);
    run_cmd(2, 4, 32'h0000_0072, '0, LEN + 1, 1'b0);
    // HIGH on ch1 held low, timeout 5
    fill_traj(32'h0000_0000);
    run_cmd(1, 0, '0, 32'd5, LEN + 1, 1'b0);
    // bad channel and reserved mode
    run_cmd(WS, 0, '0, '0, LEN + 1, 1'b0);
    run_cmd(0, 6, '0, '0, LEN + 1, 1'b0);
    // match and timeout expiry in the same cycle
    gen_traj(0, '0, 3);
    run_cmd(0, 0, '0, 32'd3, LEN + 1, 1'b0);
    // abort in the same cycle as a match, then a fresh command
    gen_traj(0, '0, 3);
    run_cmd(3, 0, '0, '0, 3, 1'b0);
    fill_traj(32'h0000_0001);
    run_cmd(4, 0, '0, '0, LEN + 1, 1'b1);

    // reset mid-wait drops the command silently
    i_start = 1'b1; i_sel = 3'd1; i_mode = 3'd0; i_timeout = '0; wait_signals = '0;
    @(negedge clk);
    i_start = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_mid_wait", 64'(o_busy), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("busy_after_reset", 64'(o_busy), 64'd0);
    check("elapsed_after_reset", 64'(o_elapsed), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("done_after_reset", 64'(o_done), 64'd0);

    // masked compare: matches with the mask, times out on a full-width compare
    fill_traj(32'hCAFE_DECA);
    cur_mask = 32'hFFFF_0000;
    run_cmd(0, 4, 32'hCAFE_0000, 32'd4, LEN + 1, 1'b0);

    for (int n = 0; n < 60; n++) begin
      int            sel, mode, d, ab;
      logic [WW-1:0] val;
      logic [TW-1:0] tmo;
      sel  = $urandom_range(0, WS - 1);
      mode = $urandom_range(0, 5);
      if ($urandom_range(0, 11) == 0) sel = $urandom_range(WS, 7);
      else if ($urandom_range(0, 11) == 0) mode = $urandom_range(6, 7);
      val = WW'($urandom);
      d = $urandom_range(0, 20);
      if ((mode == 2 || mode == 3) && d == 0) d = 1;
      tmo = ($urandom_range(0, 2) == 0) ? '0 : TW'($urandom_range(1, 25));
      ab = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 20) : LEN + 1;
      cur_mask = ($urandom_range(0, 1) == 1) ? '1 : WW'($urandom);
      gen_traj(mode, val, d);
      run_cmd(sel, mode, val, tmo, ab, ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
